doppler_estimator: RTL and testbench

- Receive-side counterpart to the NCO: measures the frequency of a returned, digitised tone and outputs the equivalent 32-bit phase-increment word (doppler_shift format, 2^32 = one cycle per sample).
- Counts rising zero crossings over NPER periods, totals the samples between them, then runs a 32-cycle sequential restoring divider to form FTW = floor(NPER * 2^32 / S).
- Sits after the ADC/IQ path so the measured word can be fed back to, or compared with, the NCO tuning input.

---
 rtl/doppler_estimator.sv | 166 ++++++++++++++++
 tb/tb_doppler_estimator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/doppler_estimator.sv
// Purpose : measures the frequency of a returned tone by timing NPER rising zero
//           crossings and converts it to a 32-bit phase-increment word
//           FTW = floor(NPER * 2^32 / S) with a 32-step restoring divider.
// Latency : ftw/ftw_valid update 33 clocks after the edge that accepts the
//           window-closing sample; busy is high for the 32 clocks in between.
// Flow    : samples are taken only when sample_valid is high; the divider runs
//           on its own. A window closing while the divider is busy is dropped
//           and flagged on overrun.
// Ports   : M100CLK      - system clock, all logic on posedge
//           reset        - synchronous, active-high
//           sample_in    - 17-bit signed sample
//           sample_valid - sample_in accepted on this edge
//           ftw          - last completed frequency word, held between updates
//           ftw_valid    - one-cycle pulse when ftw updates
//           busy         - divider iterating
//           overrun      - one-cycle pulse, window closed while divider busy
//           timeout      - one-cycle pulse, S saturated before window closed
module doppler_estimator #(
  parameter int NPER  = 16,
  parameter int CNT_W = 24,
  parameter int HYST  = 256
) (
  input  logic        M100CLK,
  input  logic        reset,
  input  logic [16:0] sample_in,
  input  logic        sample_valid,
  output logic [31:0] ftw,
  output logic        ftw_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic signed [17:0] NEG_HYST = 18'(-HYST);
  localparam logic [CNT_W-1:0]   NPER_C   = CNT_W'(NPER);
  localparam logic [CNT_W-1:0]   S_MAX    = '1;
  localparam logic [CNT_W:0]     REM_INIT = (CNT_W+1)'(NPER);
  localparam logic [5:0]         LAST_BIT = 6'd32;

  state_t           state;
  logic             arm;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] s;

  logic [CNT_W-1:0] div;
  logic [CNT_W:0]   rem;
  logic [31:0]      quot;
  logic [5:0]       bitcnt;

  // Sample classification
  logic             below;
  logic             crossing;
  logic [CNT_W-1:0] s_next;
  logic [CNT_W-1:0] cnt_next;
  logic             close_win;
  logic             div_free;
  logic             load;

  assign below    = $signed({sample_in[16], sample_in}) < NEG_HYST;
  assign crossing = sample_valid && arm && !sample_in[16];
  assign s_next   = s + CNT_W'(1);
  assign cnt_next = cnt + CNT_W'(1);

  // The closing crossing is the NPER-th crossing counted inside MEASURE.
  assign close_win = (state == MEASURE) && crossing && (cnt_next == NPER_C);

  // On the edge where the divider delivers its result it can already accept
  // a new load, so a window closing exactly then is not an overrun.
  assign div_free = !busy || (bitcnt == LAST_BIT);
  assign load     = close_win && div_free;

  // Divider step: shift, trial-subtract, restore on borrow.
  logic [CNT_W:0] rem_sh;
  logic           rem_ge;
  always_comb begin
    rem_sh = {rem[CNT_W-1:0], 1'b0};
    rem_ge = rem_sh >= {1'b0, div};
  end

  // Crossing detector and measurement FSM
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      state   <= IDLE;
      arm     <= 1'b0;
      cnt     <= '0;
      s       <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      if (sample_valid) begin
        if (crossing)
          arm <= 1'b0;
        else if (below)
          arm <= 1'b1;

        case (state)
          IDLE: begin
            if (crossing) begin
              state <= MEASURE;
              s     <= '0;
              cnt   <= '0;
            end
          end
          MEASURE: begin
            if (close_win) begin
              // The closing crossing also opens the next window.
              s   <= '0;
              cnt <= '0;
              if (!div_free)
                overrun <= 1'b1;
            end else if (s_next == S_MAX) begin
              timeout <= 1'b1;
              state   <= IDLE;
              s       <= '0;
              cnt     <= '0;
            end else begin
              s <= s_next;
              if (crossing)
                cnt <= cnt_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Restoring divider: NPER * 2^32 / S, one quotient bit per clock, MSB first.
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      busy      <= 1'b0;
      bitcnt    <= '0;
      rem       <= '0;
      div       <= '0;
      quot      <= '0;
      ftw       <= '0;
      ftw_valid <= 1'b0;
    end else begin
      ftw_valid <= 1'b0;
      if (busy) begin
        if (bitcnt == LAST_BIT) begin
          ftw       <= quot;
          ftw_valid <= 1'b1;
          busy      <= 1'b0;
        end else begin
          rem    <= rem_ge ? (rem_sh - {1'b0, div}) : rem_sh;
          quot   <= {quot[30:0], rem_ge};
          bitcnt <= bitcnt + 6'd1;
        end
      end
      // Divisor includes the closing sample, hence s_next.
      if (load) begin
        rem    <= REM_INIT;
        div    <= s_next;
        quot   <= '0;
        bitcnt <= '0;
        busy   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_doppler_estimator.sv
// Purpose : directed checks of doppler_estimator with three parameter sets
//           (NPER=4; NPER=1; NPER=4 with CNT_W=8) sharing one stimulus stream.
// Ports   : none; drives the DUT inputs and checks outputs 1 time unit after
//           each rising edge.
module tb_doppler_estimator;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] sample_in;
  logic        sample_valid;

  logic [31:0] ftw_a, ftw_b, ftw_c;
  logic        fv_a, fv_b, fv_c;
  logic        busy_a, busy_b, busy_c;
  logic        ov_a, ov_b, ov_c;
  logic        to_a, to_b, to_c;

  always #5 clk = ~clk;

  doppler_estimator #(.NPER(4)) u_a (
    .M100CLK(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .ftw(ftw_a), .ftw_valid(fv_a), .busy(busy_a), .overrun(ov_a), .timeout(to_a));

  doppler_estimator #(.NPER(1)) u_b (
    .M100CLK(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .ftw(ftw_b), .ftw_valid(fv_b), .busy(busy_b), .overrun(ov_b), .timeout(to_b));

  doppler_estimator #(.NPER(4), .CNT_W(8)) u_c (
    .M100CLK(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .ftw(ftw_c), .ftw_valid(fv_c), .busy(busy_c), .overrun(ov_c), .timeout(to_c));

  int errors = 0;
  int checks = 0;

  int cyc;
  int pulses_a[$];
  int pulses_b[$];
  int pulses_c[$];
  int ovr_b;
  int first_ovr_b;
  int to_c_cnt;
  int to_c_step;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, observe outputs and log events.
  task automatic step(input logic [16:0] s, input logic v);
    sample_in    = s;
    sample_valid = v;
    @(posedge clk);
    #1;
    if (fv_a) pulses_a.push_back(cyc);
    if (fv_b) pulses_b.push_back(cyc);
    if (fv_c) pulses_c.push_back(cyc);
    if (ov_b) begin
      if (ovr_b == 0) first_ovr_b = cyc;
      ovr_b++;
    end
    if (to_c) begin
      to_c_cnt++;
      to_c_step = cyc;
    end
    cyc++;
  endtask

  task automatic clear_log();
    pulses_a.delete();
    pulses_b.delete();
    pulses_c.delete();
    ovr_b       = 0;
    first_ovr_b = -1;
    to_c_cnt    = 0;
    to_c_step   = -1;
    cyc         = 0;
  endtask

  // Holds reset for 3 clocks and leaves it asserted; caller releases it.
  task automatic hold_reset();
    reset = 1'b1;
    repeat (3) step(17'd0, 1'b0);
  endtask

  // Square tone: 'half' samples at -1000 then 'half' at +1000.
  function automatic logic [16:0] sq(input int n, input int half);
    int v;
    v = ((n % (2 * half)) < half) ? -1000 : 1000;
    return 17'(v);
  endfunction

  // Sine of period 100 samples, amplitude 20000.
  function automatic logic [16:0] sn(input int n);
    real ph;
    ph = 2.0 * 3.14159265358979 * real'(n % 100) / 100.0;
    return 17'($rtoi(20000.0 * $sin(ph)));
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    clear_log();

    // Reset state
    hold_reset();
    check("rst_ftw", ftw_a, 32'h0);
    check("rst_flags", {28'h0, fv_a, busy_a, ov_a, to_a}, 32'h0);
    reset = 1'b0;
    clear_log();

    // NPER=4, period 16: crossings at 8,24,...; windows close at 72,136,200
    for (int n = 0; n < 240; n++) begin
      step(sq(n, 8), 1'b1);
      if (n == 72)  check("busy_after_load", 32'(busy_a), 32'h1);
      if (n == 104) check("busy_last_iter", 32'(busy_a), 32'h1);
      if (n == 105) check("busy_drop", 32'(busy_a), 32'h0);
    end
    check("sq_npulse", pulses_a.size(), 3);
    check("sq_first", qat(pulses_a, 0), 105);
    check("sq_gap1", qat(pulses_a, 1) - qat(pulses_a, 0), 64);
    check("sq_gap2", qat(pulses_a, 2) - qat(pulses_a, 1), 64);
    check("sq_ftw", ftw_a, 32'h1000_0000);

    // Reset during a divide (window closed at 264)
    for (int n = 240; n < 270; n++) step(sq(n, 8), 1'b1);
    check("mid_busy", 32'(busy_a), 32'h1);
    hold_reset();
    check("mid_rst_ftw", ftw_a, 32'h0);
    check("mid_rst_flags", {28'h0, fv_a, busy_a, ov_a, to_a}, 32'h0);
    reset = 1'b0;
    clear_log();
    for (int n = 0; n < 110; n++) step(sq(n, 8), 1'b1);
    check("post_rst_npulse", pulses_a.size(), 1);
    check("post_rst_first", qat(pulses_a, 0), 105);

    // sample_valid toggling: sample n accepted at step 2n; invalid slots carry junk
    hold_reset();
    reset = 1'b0;
    clear_log();
    for (int n = 0; n < 160; n++) begin
      step(sq(n, 8), 1'b1);
      step(17'(-30000), 1'b0);
    end
    check("tog_npulse", pulses_a.size(), 2);
    check("tog_first", qat(pulses_a, 0), 177);
    check("tog_gap", qat(pulses_a, 1) - qat(pulses_a, 0), 128);
    check("tog_ftw", ftw_a, 32'h1000_0000);

    // Sine period 100: first crossing at 100, close at 500
    hold_reset();
    reset = 1'b0;
    clear_log();
    for (int n = 0; n < 540; n++) step(sn(n), 1'b1);
    check("sin_npulse", pulses_a.size(), 1);
    check("sin_first", qat(pulses_a, 0), 533);
    check("sin_ftw", ftw_a, 32'h028F_5C28);

    // NPER=1, period 4: closes every 4 clocks, divider busy 32 -> overruns
    hold_reset();
    reset = 1'b0;
    clear_log();
    for (int n = 0; n < 76; n++) step(sq(n, 2), 1'b1);
    check("ovr_count", ovr_b, 16);
    check("ovr_first", first_ovr_b, 10);
    check("ovr_npulse", pulses_b.size(), 2);
    check("ovr_pulse0", qat(pulses_b, 0), 39);
    check("ovr_pulse1", qat(pulses_b, 1), 75);
    check("ovr_ftw", ftw_b, 32'h4000_0000);

    // CNT_W=8: one crossing then constant +500 -> timeout when S reaches 255
    hold_reset();
    reset = 1'b0;
    clear_log();
    step(17'(-1000), 1'b1);
    for (int n = 1; n < 300; n++) step(17'd500, 1'b1);
    check("to_count", to_c_cnt, 1);
    check("to_step", to_c_step, 256);
    check("to_npulse", pulses_c.size(), 0);
    check("to_ftw", ftw_c, 32'h0);

    // Chatter inside the hysteresis band never arms
    for (int n = 0; n < 300; n++) step((n % 2) ? 17'd100 : 17'(-100), 1'b1);
    check("chat_to_count", to_c_cnt, 1);
    check("chat_npulse_c", pulses_c.size(), 0);
    check("chat_npulse_a", pulses_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
